// File: rtl/rsub_div_ctrl.sv
// Sequencing FSM for the repeated-add accumulator: quotient/remainder by repeated subtraction.
// Optional feature: define RSUB_DIV_CTRL_START_ABORT_EN to let start restart a busy operation.
module rsub_div_ctrl #(
    parameter int CNT_W    = 32,
    parameter int MAX_ITER = 1024
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             x,
    output logic             s,
    output logic             we,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] quotient
);

    typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] quotient_nxt;
    logic             err_q, err_nxt;
    logic             wrote;
    logic             at_limit;
    logic             abort_req;

    assign at_limit = (quotient == CNT_W'(MAX_ITER));

`ifdef RSUB_DIV_CTRL_START_ABORT_EN
    assign abort_req = start & ((state == LOAD) | (state == ITER));
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            quotient <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            quotient <= quotient_nxt;
            err_q    <= err_nxt;
        end
    end

    // The datapath writes on the negedge, after which x already shows the next sum;
    // capture whether this ITER cycle actually wrote so the posedge counts that write.
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            wrote <= 1'b0;
        end else begin
            wrote <= (state == ITER) & we;
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path infers a latch.
        state_nxt    = state;
        quotient_nxt = quotient;
        err_nxt      = err_q;
        s            = 1'b0;
        we           = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        err          = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt    = LOAD;
                    quotient_nxt = '0;
                    err_nxt      = 1'b0;
                end
            end
            LOAD: begin
                we        = 1'b1;
                busy      = 1'b1;
                state_nxt = ITER;
            end
            ITER: begin
                s    = 1'b1;
                busy = 1'b1;
                we   = ~x & ~at_limit;
                if (wrote) begin
                    quotient_nxt = quotient + CNT_W'(1);
                end else begin
                    // A stall with a non-negative sum can only mean the limit stopped us.
                    state_nxt = DONE;
                    err_nxt   = at_limit & ~x;
                end
            end
            DONE: begin
                done      = 1'b1;
                err       = err_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (abort_req) begin
            state_nxt    = LOAD;
            quotient_nxt = '0;
            err_nxt      = 1'b0;
        end
    end

endmodule

// File: tb/tb_rsub_div_ctrl.sv
// Bench for rsub_div_ctrl: two instances (default limit and MAX_ITER=8) each driving a
// behavioural accumulator datapath, checked every cycle against an arithmetic timeline model.
module tb_rsub_div_ctrl;

    localparam int NI  = 2;
    localparam int BIG = 1000000;

`ifdef RSUB_DIV_CTRL_START_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [NI-1:0] start_v = '0;
    logic [31:0]   a_v  [NI] = '{32'd0, 32'd0};
    logic [31:0]   b_v  [NI] = '{32'd0, 32'd0};
    logic [31:0]   temp [NI] = '{32'd0, 32'd0};
    int            max_v [NI] = '{1024, 8};

    wire  [NI-1:0] s_v, we_v, busy_v, done_v, err_v;
    wire  [31:0]   quot_v [NI];
    wire  [31:0]   sum0 = temp[0] + b_v[0];
    wire  [31:0]   sum1 = temp[1] + b_v[1];
    wire  [NI-1:0] x_v  = {sum1[31], sum0[31]};

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model state: cycles since the accepted start, expected quotient/remainder/err.
    int          rel  [NI] = '{BIG, BIG};
    int          mq   [NI] = '{0, 0};
    logic        merr [NI] = '{1'b0, 1'b0};
    logic [31:0] mrem [NI] = '{32'd0, 32'd0};

    always #5 CLK = ~CLK;

    rsub_div_ctrl #(.CNT_W(32), .MAX_ITER(1024)) dut (
        .CLK(CLK), .RST(RST), .start(start_v[0]), .x(x_v[0]), .s(s_v[0]), .we(we_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]), .quotient(quot_v[0])
    );

    rsub_div_ctrl #(.CNT_W(32), .MAX_ITER(8)) dut_lim (
        .CLK(CLK), .RST(RST), .start(start_v[1]), .x(x_v[1]), .s(s_v[1]), .we(we_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]), .quotient(quot_v[1])
    );

    // Accumulator datapath: temp written on the negedge.
    always @(negedge CLK) begin
        for (int i = 0; i < NI; i++) begin
            if (we_v[i]) temp[i] <= s_v[i] ? temp[i] + b_v[i] : a_v[i];
        end
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Division by repeated subtraction with an iteration limit.
    function automatic void model_div(input logic [31:0] a, input logic [31:0] b, input int max,
                                      output int q, output logic [31:0] r, output logic e);
        logic [31:0] sm;
        q = 0;
        r = a;
        e = 1'b0;
        forever begin
            sm = r + b;
            if (sm[31]) break;
            if (q == max) begin
                e = 1'b1;
                break;
            end
            r = sm;
            q++;
        end
    endfunction

    // Model update at each edge, then compare every output of both instances.
    always @(posedge CLK) begin : compare
        int          r, q;
        logic [4:0]  exp_ctl, act_ctl;
        logic [31:0] exp_q;
        for (int i = 0; i < NI; i++) begin
            if (RST) begin
                rel[i]  = BIG;
                mq[i]   = 0;
                merr[i] = 1'b0;
                mrem[i] = 32'd0;
            end else if ((rel[i] > mq[i] + 2 && start_v[i]) ||
                         (ABORT && start_v[i] && rel[i] <= mq[i] + 1)) begin
                rel[i] = 0;
                model_div(a_v[i], b_v[i], max_v[i], mq[i], mrem[i], merr[i]);
            end else if (rel[i] < BIG) begin
                rel[i]++;
            end
        end
        #1;
        if (!RST) begin
            for (int i = 0; i < NI; i++) begin
                r = rel[i];
                q = mq[i];
                exp_ctl = {r <= q + 1, r >= 1 && r <= q + 1, r == 0 || (r >= 1 && r <= q),
                           r == q + 2, r == q + 2 && merr[i]};
                act_ctl = {busy_v[i], s_v[i], we_v[i], done_v[i], err_v[i]};
                exp_q   = (r == 0) ? 32'd0 : (r <= q + 1) ? 32'(r - 1) : 32'(q);
                check($sformatf("ctl{busy,s,we,done,err} inst%0d cyc%0d", i, cyc),
                      32'(act_ctl), 32'(exp_ctl));
                check($sformatf("quotient inst%0d cyc%0d", i, cyc), quot_v[i], exp_q);
                if (r == q + 2)
                    check($sformatf("remainder inst%0d cyc%0d", i, cyc), temp[i], mrem[i]);
            end
        end
    end

    task automatic wait_done(input int i, input int budget, output int at_cyc, output bit seen);
        seen   = 1'b0;
        at_cyc = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(posedge CLK);
            #1;
            if (done_v[i]) begin
                seen   = 1'b1;
                at_cyc = cyc;
            end
        end
    endtask

    task automatic check_idle(input int i, input string tag);
        check({tag, " ctl"}, 32'({busy_v[i], s_v[i], we_v[i], done_v[i], err_v[i]}), 32'd0);
        check({tag, " quotient"}, quot_v[i], 32'd0);
    endtask

    task automatic run_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input int eq, input logic [31:0] er, input bit ee,
                          input int elat, input string tag);
        int n, d;
        bit seen;
        @(posedge CLK);
        #3;
        a_v[i] = a;
        b_v[i] = b;
        start_v[i] = 1'b1;
        @(posedge CLK);
        #1;
        n = cyc;
        #2;
        start_v[i] = 1'b0;
        wait_done(i, 2000, d, seen);
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(d - n), 32'(elat));
        check({tag, " quotient"}, quot_v[i], 32'(eq));
        check({tag, " remainder"}, temp[i], er);
        check({tag, " err"}, 32'(err_v[i]), 32'(ee));
    endtask

    initial begin : stim
        int  n, n2, d, d1, d2, pulses;
        bit  seen, seen1, seen2;

        repeat (2) @(posedge CLK);
        #1;
        check_idle(0, "reset inst0");
        check_idle(1, "reset inst1");
        #2;
        RST = 1'b0;

        run_op(0, 32'd17,        32'hFFFF_FFFB, 3, 32'd2,         1'b0, 5,  "div17by5");
        run_op(0, 32'd4,         32'hFFFF_FFFC, 1, 32'd0,         1'b0, 3,  "div4by4");
        run_op(0, 32'hFFFF_FFF6, 32'hFFFF_FFFD, 0, 32'hFFFF_FFF6, 1'b0, 2,  "neg_a");
        run_op(1, 32'd5,         32'd0,         8, 32'd5,         1'b1, 10, "runaway");

        // Asynchronous reset in the middle of ITER.
        @(posedge CLK);
        #3;
        a_v[0] = 32'd17;
        b_v[0] = 32'hFFFF_FFFB;
        start_v[0] = 1'b1;
        @(posedge CLK);
        #3;
        start_v[0] = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check_idle(0, "rst_mid_iter");
        @(posedge CLK);
        #3;
        RST = 1'b0;
        run_op(0, 32'd9, 32'hFFFF_FFFC, 2, 32'd1, 1'b0, 4, "after_rst");

        // Second start two cycles into a long operation.
        @(posedge CLK);
        #3;
        a_v[0] = 32'd100;
        b_v[0] = 32'hFFFF_FFFF;
        start_v[0] = 1'b1;
        @(posedge CLK);
        #1;
        n = cyc;
        #2;
        start_v[0] = 1'b0;
        @(posedge CLK);
        #3;
        if (ABORT) begin
            a_v[0] = 32'd7;
            b_v[0] = 32'hFFFF_FFFD;
        end
        start_v[0] = 1'b1;
        @(posedge CLK);
        #1;
        n2 = cyc;
        #2;
        start_v[0] = 1'b0;
        wait_done(0, 300, d, seen);
        pulses = seen ? 1 : 0;
        check("second_start done_seen", 32'(seen), 32'd1);
        check("second_start latency", 32'(ABORT ? d - n2 : d - n), ABORT ? 32'd4 : 32'd102);
        check("second_start quotient", quot_v[0], ABORT ? 32'd2 : 32'd100);
        check("second_start remainder", temp[0], ABORT ? 32'd1 : 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(posedge CLK);
            #1;
            if (done_v[0]) pulses++;
        end
        check("second_start done_pulses", 32'(pulses), 32'd1);

        // start held high: back-to-back operations.
        @(posedge CLK);
        #3;
        a_v[0] = 32'd6;
        b_v[0] = 32'hFFFF_FFFD;
        start_v[0] = 1'b1;
        wait_done(0, 50, d1, seen1);
        wait_done(0, 50, d2, seen2);
        #2;
        start_v[0] = 1'b0;
        check("held_start both_done", 32'({seen1, seen2}), 32'd3);
        check("held_start gap", 32'(d2 - d1), 32'd6);
        check("held_start quotient", quot_v[0], 32'd2);
        check("held_start remainder", temp[0], 32'd0);

        repeat (4) @(posedge CLK);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
